// File: rtl/proc_core_p.sv
// Parametrised demo processor core: fetch/execute FSM stepped by a clock-enable
// divider, ALU with carry/zero flags, branches, HALT and a strobed output port.
module proc_core_p #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int ROM_AW   = 4,
  parameter int STEP_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  output logic [ROM_AW-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ROM_AW-1:0] out_pc,
  output logic              out_valid,
  output logic              halted,
  // Debug view: state (0 fetch, 1 exec, 2 halt) and flags {Z, C}.
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_zc
);
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_BNZ  = 4'b1101;
  localparam logic [3:0] OP_MOV  = 4'b1110;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [ROM_AW-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ROM_AW-1:0] out_pc_q, out_pc_d;
  logic              out_valid_q, out_valid_d;

  logic              tick;
  logic [3:0]        op;
  logic [2:0]        ra_idx, rb_idx;
  logic [DATA_W-1:0] imm, ra_val, rb_val, opnd;
  logic [ROM_AW-1:0] tgt;
  logic [DATA_W:0]   sum, dif;
  logic              wr_en;
  logic [DATA_W-1:0] wr_val;

  assign tick = run_en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (run_en) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
  end

  // Decode; unimplemented register indices simply never match and read as 0.
  always_comb begin
    op     = imem_data[15:12];
    ra_idx = imem_data[11:9];
    rb_idx = imem_data[8:6];
    imm    = DATA_W'(imem_data[7:0]);
    tgt    = ROM_AW'(imem_data[11:0]);
    ra_val = '0;
    rb_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ra_idx == 3'(i)) ra_val = regs_q[i];
      if (rb_idx == 3'(i)) rb_val = regs_q[i];
    end
    opnd = op[3] ? imm : rb_val;
    sum  = {1'b0, ra_val} + {1'b0, opnd};
    dif  = {1'b0, ra_val} - {1'b0, opnd};
  end

  // out_valid is a one-clk strobe with no back-pressure; out_data/out_pc hold
  // their value until the next OUT commits.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    z_d         = z_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_val      = '0;
    if (tick) begin
      case (state_q)
        ST_FETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          state_d = ST_FETCH;
          pc_d    = pc_q + ROM_AW'(1);
          case (op)
            OP_LDI: begin
              wr_en  = 1'b1;
              wr_val = imm;
            end
            OP_ADD, OP_ADDI: begin
              wr_en  = 1'b1;
              wr_val = sum[DATA_W-1:0];
              c_d    = sum[DATA_W];
              z_d    = (sum[DATA_W-1:0] == '0);
            end
            OP_SUB, OP_SUBI: begin
              wr_en  = 1'b1;
              wr_val = dif[DATA_W-1:0];
              c_d    = dif[DATA_W];
              z_d    = (dif[DATA_W-1:0] == '0);
            end
            OP_MOV: begin
              wr_en  = 1'b1;
              wr_val = rb_val;
            end
            OP_JMP: pc_d = tgt;
            OP_BZ:  if (z_q) pc_d = tgt;
            OP_BNZ: if (!z_q) pc_d = tgt;
            OP_OUT: begin
              out_data_d  = ra_val;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
            end
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = (wr_en && (ra_idx == 3'(i))) ? wr_val : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      pc_q        <= pc_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;
  assign dbg_zc    = {z_q, c_q};
endmodule

// File: tb/tb_proc_core_p.sv
// Bench for proc_core_p: two instances (16-bit/8 regs/every cycle and
// 8-bit/6 regs/divide-by-4) run the same ROM against an instruction-level model.
`timescale 1ns/1ps
module tb_proc_core_p;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b1;
  logic [3:0]  addr0, addr1, opc0, opc1;
  logic [15:0] imd0, imd1, od0;
  logic [7:0]  od1;
  logic        ov0, ov1, hl0, hl1;
  logic [1:0]  st0, st1, zc0, zc1;
  logic [15:0] rom [16];

  always #5 clk = ~clk;

  proc_core_p #(.DATA_W(16), .NREG(8), .ROM_AW(4), .STEP_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .run_en(run_en), .imem_addr(addr0), .imem_data(imd0),
    .out_data(od0), .out_pc(opc0), .out_valid(ov0), .halted(hl0),
    .dbg_state(st0), .dbg_zc(zc0));

  proc_core_p #(.DATA_W(8), .NREG(6), .ROM_AW(4), .STEP_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .run_en(run_en), .imem_addr(addr1), .imem_data(imd1),
    .out_data(od1), .out_pc(opc1), .out_valid(ov1), .halted(hl1),
    .dbg_state(st1), .dbg_zc(zc1));

  // Synchronous-read ROM, one read port per instance.
  always @(posedge clk) begin
    imd0 <= rom[addr0];
    imd1 <= rom[addr1];
  end

  function automatic int k_dw(input int k);  return (k == 0) ? 16 : 8; endfunction
  function automatic int k_nr(input int k);  return (k == 0) ? 8 : 6;  endfunction
  function automatic int k_div(input int k); return (k == 0) ? 1 : 4;  endfunction

  // Instruction-level model: phase 0 fetch, 1 exec, 2 halted.
  int m_pc[2], m_z[2], m_c[2], m_ph[2], m_cnt[2], m_od[2], m_opc[2], m_ov[2];
  int m_reg[2][8];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  task automatic m_reset(input int k);
    m_pc[k] = 0; m_z[k] = 0; m_c[k] = 0; m_ph[k] = 0; m_cnt[k] = 0;
    m_od[k] = 0; m_opc[k] = 0; m_ov[k] = 0;
    for (int i = 0; i < 8; i++) m_reg[k][i] = 0;
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  function automatic int m_rd(input int k, input int idx);
    return (idx < k_nr(k)) ? m_reg[k][idx] : 0;
  endfunction

  task automatic m_exec(input int k);
    logic [15:0] ins;
    int op, ra, rb, imm, tgt, a, b, mask, r, wv, nxt;
    bit wr;
    ins  = rom[m_pc[k]];
    op   = int'(ins[15:12]);
    ra   = int'(ins[11:9]);
    rb   = int'(ins[8:6]);
    imm  = int'(ins[7:0]);
    tgt  = int'(ins[11:0]) % 16;
    mask = (1 << k_dw(k)) - 1;
    a    = m_rd(k, ra);
    b    = m_rd(k, rb);
    wr   = 1'b0;
    wv   = 0;
    nxt  = (m_pc[k] + 1) % 16;
    m_ph[k] = 0;
    case (op)
      1: begin wr = 1'b1; wv = imm; end
      2, 10: begin
        r = a + ((op == 2) ? b : imm);
        m_c[k] = (r > mask) ? 1 : 0;
        wv = r & mask;
        m_z[k] = (wv == 0) ? 1 : 0;
        wr = 1'b1;
      end
      3, 11: begin
        r = (op == 3) ? b : imm;
        m_c[k] = (a < r) ? 1 : 0;
        wv = (a - r) & mask;
        m_z[k] = (wv == 0) ? 1 : 0;
        wr = 1'b1;
      end
      14: begin wr = 1'b1; wv = b; end
      8:  nxt = tgt;
      12: if (m_z[k] != 0) nxt = tgt;
      13: if (m_z[k] == 0) nxt = tgt;
      15: begin
        m_od[k] = a; m_opc[k] = m_pc[k]; m_ov[k] = 1;
        if (k == 0) exp_q0.push_back(32'((m_pc[k] << 16) | a));
        else        exp_q1.push_back(32'((m_pc[k] << 16) | a));
      end
      4: m_ph[k] = 2;
      default: ;
    endcase
    if (wr && ra < k_nr(k)) m_reg[k][ra] = wv & mask;
    m_pc[k] = nxt;
  endtask

  task automatic m_step(input int k);
    m_ov[k] = 0;
    if (rst) m_reset(k);
    else if (run_en) begin
      if (m_cnt[k] == k_div(k) - 1) begin
        m_cnt[k] = 0;
        if (m_ph[k] == 0) m_ph[k] = 1;
        else if (m_ph[k] == 1) m_exec(k);
      end else m_cnt[k]++;
    end
  endtask

  always @(posedge clk) begin
    m_step(0);
    m_step(1);
  end

  // Scoreboard and compare process.
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int out_log0[$];
  int out_log1[$];
  int addr_log[$];
  int addr_prev = 0;
  int ov_cnt0 = 0;
  int ov_cnt1 = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: actual=%0h required=%0h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] addr, input logic ov, input logic [15:0] od,
                     input logic [3:0] opc, input logic hl, input logic [1:0] st, input logic [1:0] zc);
    logic [31:0] e;
    int sz;
    check("imem_addr", k, 32'(addr), 32'(m_pc[k]));
    check("out_valid", k, 32'(ov), 32'(m_ov[k]));
    check("out_data", k, 32'(od), 32'(m_od[k]));
    check("out_pc", k, 32'(opc), 32'(m_opc[k]));
    check("halted", k, 32'(hl), (m_ph[k] == 2) ? 32'd1 : 32'd0);
    check("state", k, 32'(st), 32'(m_ph[k]));
    check("flags_zc", k, 32'(zc), 32'(m_z[k] * 2 + m_c[k]));
    if (ov) begin
      sz = (k == 0) ? exp_q0.size() : exp_q1.size();
      check("sb_avail", k, (sz > 0) ? 32'd1 : 32'd0, 32'd1);
      e = '1;
      if (sz > 0) e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check("sb_out", k, {12'd0, opc, od}, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, addr0, ov0, od0, opc0, hl0, st0, zc0);
      cmp(1, addr1, ov1, {8'h00, od1}, opc1, hl1, st1, zc1);
      if (ov0) begin out_log0.push_back(int'(od0)); ov_cnt0++; end
      if (ov1) begin out_log1.push_back(int'(od1)); ov_cnt1++; end
      if (int'(addr0) != addr_prev) begin
        addr_log.push_back(int'(addr0));
        addr_prev = int'(addr0);
      end
    end
  end

  // Driver tasks.
  function automatic logic [15:0] e_ri(input logic [3:0] op, input logic [2:0] ra, input logic [7:0] imm);
    return {op, ra, 1'b0, imm};
  endfunction
  function automatic logic [15:0] e_rr(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb, 6'd0};
  endfunction
  function automatic logic [15:0] e_j(input logic [3:0] op, input logic [11:0] t);
    return {op, t};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    run_en = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  task automatic rel_reset();
    step(1);
    rst = 1'b0;
    cyc = 0;
    out_log0.delete();
    out_log1.delete();
    addr_log.delete();
    addr_prev = 0;
    ov_cnt0 = 0;
    ov_cnt1 = 0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!(hl0 && hl1) && n < budget) begin
      step(1);
      n++;
    end
    check(name, 0, {31'd0, hl0 && hl1}, 32'd1);
  endtask

  task automatic load_prog1();
    rom[0] = e_ri(4'h1, 3'd1, 8'd5);
    rom[1] = e_ri(4'h1, 3'd2, 8'd3);
    rom[2] = e_rr(4'h2, 3'd1, 3'd2);
    rom[3] = e_rr(4'hF, 3'd1, 3'd0);
    rom[4] = e_rr(4'h4, 3'd0, 3'd0);
  endtask

  initial begin
    int h0, h1;
    int exp_a[7];
    logic [3:0] rop;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    step(2);
    chk_en = 1'b1;
    check("rst_addr", 0, 32'(addr0), 32'd0);
    check("rst_addr", 1, 32'(addr1), 32'd0);
    check("rst_valid", 0, 32'(ov0), 32'd0);
    check("rst_halted", 1, 32'(hl1), 32'd0);
    check("rst_zc", 0, 32'(zc0), 32'd0);
    check("rst_data", 1, 32'(od1), 32'd0);

    // Basic program, cycle-exact at one step per clk.
    hold_reset(); load_prog1(); rel_reset();
    step(7);
    check("p1_valid_c7", 0, 32'(ov0), 32'd0);
    step(1);
    check("p1_valid_c8", 0, 32'(ov0), 32'd1);
    check("p1_data_c8", 0, 32'(od0), 32'd8);
    check("p1_pc_c8", 0, 32'(opc0), 32'd3);
    check("p1_model_data", 0, 32'(m_od[0]), 32'd8);
    step(1);
    check("p1_halt_c9", 0, 32'(hl0), 32'd0);
    step(1);
    check("p1_halt_c10", 0, 32'(hl0), 32'd1);
    wait_halt("p1_halt_both", 300);
    check("p1_data_i1", 1, 32'(od1), 32'd8);

    // 8-bit wrap sets Z and C and takes BZ; 16-bit falls through.
    hold_reset();
    rom[0] = e_ri(4'h1, 3'd1, 8'hFF);
    rom[1] = e_ri(4'hA, 3'd1, 8'd1);
    rom[2] = e_j(4'hC, 12'd6);
    rom[3] = e_rr(4'hF, 3'd1, 3'd0);
    rom[4] = e_rr(4'h4, 3'd0, 3'd0);
    rom[6] = e_rr(4'hF, 3'd1, 3'd0);
    rom[7] = e_rr(4'h4, 3'd0, 3'd0);
    rel_reset();
    wait_halt("p2_halt", 300);
    check("p2_data", 1, 32'(od1), 32'd0);
    check("p2_pc", 1, 32'(opc1), 32'd6);
    check("p2_zc", 1, 32'(zc1), 32'd3);
    check("p2_data", 0, 32'(od0), 32'h100);
    check("p2_pc", 0, 32'(opc0), 32'd3);
    check("p2_zc", 0, 32'(zc0), 32'd0);

    // Countdown loop.
    hold_reset();
    rom[0] = e_ri(4'h1, 3'd1, 8'd3);
    rom[1] = e_ri(4'hB, 3'd1, 8'd1);
    rom[2] = e_rr(4'hF, 3'd1, 3'd0);
    rom[3] = e_j(4'hD, 12'd1);
    rom[4] = e_rr(4'h4, 3'd0, 3'd0);
    rel_reset();
    wait_halt("p3_halt", 600);
    check("p3_count", 0, 32'(out_log0.size()), 32'd3);
    check("p3_count", 1, 32'(out_log1.size()), 32'd3);
    if (out_log0.size() == 3) begin
      check("p3_out0", 0, 32'(out_log0[0]), 32'd2);
      check("p3_out1", 0, 32'(out_log0[1]), 32'd1);
      check("p3_out2", 0, 32'(out_log0[2]), 32'd0);
    end
    check("p3_zc", 0, 32'(zc0), 32'd2);
    check("p3_zc", 1, 32'(zc1), 32'd2);

    // Truncated jump target and pc wrap from 15 to 0.
    hold_reset();
    rom[0]  = e_j(4'hD, 12'd3);
    rom[1]  = e_rr(4'hF, 3'd1, 3'd0);
    rom[2]  = e_rr(4'h4, 3'd0, 3'd0);
    rom[3]  = e_ri(4'hB, 3'd1, 8'd0);
    rom[4]  = e_j(4'h8, 12'h01F);
    rom[15] = 16'h0000;
    rel_reset();
    wait_halt("p4_halt", 600);
    exp_a = '{3, 4, 15, 0, 1, 2, 3};
    check("p4_addr_len", 0, 32'(addr_log.size()), 32'd7);
    if (addr_log.size() == 7) begin
      for (int i = 0; i < 7; i++) check("p4_addr_seq", 0, 32'(addr_log[i]), 32'(exp_a[i]));
    end
    check("p4_out_pc", 0, 32'(opc0), 32'd1);

    // run_en low for 10 clk mid-program.
    hold_reset(); load_prog1(); rel_reset();
    h0 = -1;
    h1 = -1;
    step(5);
    run_en = 1'b0;
    step(10);
    run_en = 1'b1;
    while ((h0 < 0 || h1 < 0) && cyc < 200) begin
      step(1);
      if (hl0 && h0 < 0) h0 = cyc;
      if (hl1 && h1 < 0) h1 = cyc;
    end
    check("freeze_halt_cyc", 0, 32'(h0), 32'd20);
    check("freeze_halt_cyc", 1, 32'(h1), 32'd50);
    check("freeze_pulses", 0, 32'(ov_cnt0), 32'd1);
    check("freeze_pulses", 1, 32'(ov_cnt1), 32'd1);

    // Reset during EXEC of ADD r1,r2 with r1=5.
    hold_reset(); load_prog1(); rel_reset();
    step(5);
    rst = 1'b1;
    step(1);
    check("mrst_addr", 0, 32'(addr0), 32'd0);
    check("mrst_zc", 0, 32'(zc0), 32'd0);
    check("mrst_valid", 0, 32'(ov0), 32'd0);
    check("mrst_halted", 0, 32'(hl0), 32'd0);
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = e_rr(4'hF, 3'd1, 3'd0);
    rom[1] = e_rr(4'h4, 3'd0, 3'd0);
    rel_reset();
    wait_halt("mrst_halt", 300);
    check("mrst_outs", 0, 32'(out_log0.size()), 32'd1);
    check("mrst_r1", 0, 32'(od0), 32'd0);
    check("mrst_r1", 1, 32'(od1), 32'd0);

    // Random programs with random run_en and occasional reset.
    for (int p = 0; p < 6; p++) begin
      hold_reset();
      for (int i = 0; i < 16; i++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'h4 && $urandom_range(0, 3) != 0) rop = 4'h2;
        rom[i] = {rop, 12'($urandom_range(0, 4095))};
      end
      rel_reset();
      for (int c = 0; c < 400; c++) begin
        run_en = ($urandom_range(0, 7) != 0);
        rst = ($urandom_range(0, 149) == 0);
        step(1);
      end
      rst = 1'b0;
      run_en = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/proc_core_p.md
Name: proc_core_p

Overview:
- Parametrised successor of the 16-bit demo processor: same 16-bit instruction format and opcode map, with configurable data width, register count and ROM depth.
- Replaces the hard-coded timer scaling with a STEP_DIV clock-enable divider plus a run_en gate.
- Adds a two-state fetch/execute FSM, carry and zero flags, BNZ, HALT, and a strobed output port.
- Sits between the instruction ROM (synchronous read) and the board display/debug logic.

Parameters:
- DATA_W, 16, register/ALU width; must be >= 8.
- NREG, 8, number of registers; must be <= 8 (3-bit fields).
- ROM_AW, 4, program counter / ROM address width; must be <= 12.
- STEP_DIV, 50000000, clk cycles per FSM step; 1 = every cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- run_en  in  1  1 = divider counts and FSM may advance; 0 = freeze all state.
- imem_addr  out  ROM_AW  ROM read address (= pc).
- imem_data  in  16  ROM data, valid 1 clk after imem_addr changes.
- out_data  out  DATA_W  value of ra captured by OUT.
- out_pc  out  ROM_AW  pc of the OUT instruction that produced out_data.
- out_valid  out  1  one-clk pulse when out_data/out_pc update.
- halted  out  1  high while in HALT state.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: pc=0, all regs=0, Z=0, C=0, out_data=0, out_pc=0, out_valid=0, halted=0, state=FETCH, divider=0.
- Reset mid-instruction: the instruction is abandoned with no register or flag write.
- Divider: counts 0..STEP_DIV-1 while run_en=1 and wraps. tick=1 when count==STEP_DIV-1. With STEP_DIV=1, tick=run_en every cycle. run_en=0 holds the count.
- FSM advances only on tick:
  - FETCH: imem_addr=pc. On tick -> EXEC.
  - EXEC: decode imem_data, commit results. On tick -> FETCH, or -> HALT for the HALT opcode.
  - HALT: absorbing; only rst exits. halted=1, pc frozen, no register writes.
- Latency: 2 ticks per instruction (2 clk at STEP_DIV=1).
- Fields: op=[15:12], ra=[11:9], rb=[8:6], imm=[7:0] zero-extended to DATA_W, tgt=[11:0] truncated to ROM_AW.
- Register indices >= NREG read as 0; writes to them are dropped.
- Opcodes:
  - 0000 NOP.
  - 0001 LDI: ra=imm.
  - 0010 ADD: ra=ra+rb.
  - 1010 ADDI: ra=ra+imm.
  - 0011 SUB: ra=ra-rb.
  - 1011 SUBI: ra=ra-imm.
  - 1110 MOV: ra=rb.
  - 1000 JMP: pc=tgt.
  - 1100 BZ: pc=tgt if Z=1.
  - 1101 BNZ: pc=tgt if Z=0.
  - 1111 OUT: out_data=ra, out_pc=pc, out_valid=1 for exactly 1 clk.
  - 0100 HALT.
  - Any other opcode: NOP.
- Arithmetic: DATA_W-bit, wraps modulo 2^DATA_W.
  - ADD/ADDI: C = carry-out.
  - SUB/SUBI: C = borrow (1 when ra < operand, unsigned).
  - Z = (result == 0) for ADD, ADDI, SUB, SUBI only.
  - LDI, MOV, OUT, NOP and all jumps/branches leave Z and C unchanged.
- PC update in EXEC: pc = taken ? tgt : pc+1 mod 2^ROM_AW. A jump to the current pc is legal (spin loop).
- Register writes, flag updates and the pc update all commit on the EXEC tick edge. Operands use the pre-write values.
- out_valid is a single clk pulse even when STEP_DIV > 1; 0 otherwise.
- imem_addr must be stable through FETCH and EXEC.

Test Plan:
- STEP_DIV=1, program LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HALT -> out_valid pulse at clk 8 with out_data=8, out_pc=3; halted=1 from clk 10.
- DATA_W=8: LDI r1,0xFF; ADDI r1,1; BZ 6 -> r1=0, Z=1, C=1, next imem_addr=6.
- Countdown: LDI r1,3; SUBI r1,1; OUT r1; BNZ 1; HALT -> outputs 2,1,0 in order; halt reached; final C=0.
- ROM_AW=4, pc=15 executing NOP -> next imem_addr=0. JMP with tgt=0x01F -> pc=0xF.
- STEP_DIV=4, run_en toggled low for 10 clk mid-program -> no state change while low; instruction count unaffected; out_valid still exactly 1 clk wide.
- rst asserted in EXEC of ADD r1,r2 (r1=5) -> r1 reads 0 after reset, pc=0, Z=C=0, out_valid=0, halted=0.
